// File: rtl/router_pkg.sv
// router_pkg
// Shared definitions for the router packet register stage: default word and
// address-field widths, hold-queue entry layout and tag values, and helpers
// for picking apart a header word.
package router_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    // Tag carried with every word parked in the hold queue, so draining can
    // tell when the parity word leaves.
    localparam logic TAG_PAYLOAD = 1'b0;
    localparam logic TAG_PARITY  = 1'b1;

    typedef struct packed {
        logic              tag;
        logic [DATA_W-1:0] data;
    } hold_entry_t;

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] hdr);
        return hdr[ADDR_W-1:0];
    endfunction

    function automatic logic [DATA_W-ADDR_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
        return hdr[DATA_W-1:ADDR_W];
    endfunction

    function automatic logic addr_valid(input int unsigned addr, input int unsigned num_ports);
        return addr < num_ports;
    endfunction

endpackage

// File: rtl/router_hold_q.sv
// router_hold_q
// Small circular FIFO that parks words while the destination FIFO is full.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   push, wr_data     - enqueue request and word; ignored when full
//   pop               - dequeue request; ignored when empty
//   rd_data           - head entry (valid when !empty)
//   count, full, empty- occupancy status
module router_hold_q #(
    parameter int  DEPTH = 2,
    parameter int  W     = 9,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     wr_data,
    input  logic             pop,
    output logic [W-1:0]     rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/router_pkt_reg.sv
// router_pkt_reg
// Packet register stage between the router FSM and the per-port output FIFOs.
// Captures/validates the header, forwards header, payload and parity words to
// dout, parks words in a hold queue while the FIFO is full, and checks running
// XOR parity and payload length against the header.
// Ports:
//   clock, reset                    - rising-edge clock, sync active-high reset
//   pkt_valid, data_in              - source word and valid (low in ld = parity)
//   fifo_full                       - selected output FIFO is full
//   detect_add, lfd_state, ld_state,
//   laf_state, full_state,
//   rst_int_reg                     - router FSM state strobes
//   dout, dout_valid                - registered word and write strobe to FIFO
//   hold_count, hold_empty          - hold-queue occupancy
//   low_packet_valid, parity_done   - parity word received / written out
//   err, len_err, hold_ovf          - parity, length and hold-overflow errors
module router_pkt_reg #(
    parameter int  DATA_W     = router_pkg::DATA_W,
    parameter int  ADDR_W     = router_pkg::ADDR_W,
    parameter int  NUM_PORTS  = 3,
    parameter int  HOLD_DEPTH = 2,
    localparam int HC_W       = $clog2(HOLD_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [HC_W-1:0]   hold_count,
    output logic              hold_empty,
    output logic              low_packet_valid,
    output logic              parity_done,
    output logic              err,
    output logic              len_err,
    output logic              hold_ovf
);
    import router_pkg::*;

    localparam int LEN_W = DATA_W - ADDR_W;

    // Hold entry layout at this instance's word width: tag on top of data.
    typedef struct packed {
        logic              tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [DATA_W-1:0] hdr_q, hdr_d;
    logic [DATA_W-1:0] ip_q, ip_d;
    logic [DATA_W-1:0] pp_q, pp_d;
    logic [LEN_W-1:0]  len_exp_q, len_exp_d;
    logic [LEN_W-1:0]  pay_cnt_q, pay_cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              lpv_q, lpv_d;
    logic              parity_done_q, parity_done_d;
    logic              err_q, err_d;
    logic              len_err_q, len_err_d;
    logic              hold_ovf_q, hold_ovf_d;

    logic              hq_push, hq_pop, hq_full, hq_empty;
    entry_t            hq_wr, hq_rd;
    logic              can_emit;

    router_hold_q #(
        .DEPTH (HOLD_DEPTH),
        .W     (DATA_W + 1)
    ) u_hold_q (
        .clock   (clock),
        .reset   (reset),
        .push    (hq_push),
        .wr_data (hq_wr),
        .pop     (hq_pop),
        .rd_data (hq_rd),
        .count   (hold_count),
        .full    (hq_full),
        .empty   (hq_empty)
    );

    // A word may bypass the queue only when nothing older is still parked,
    // otherwise it would overtake queued words.
    assign can_emit = !fifo_full && hq_empty;

    always_comb begin
        hdr_d         = hdr_q;
        ip_d          = ip_q;
        pp_d          = pp_q;
        len_exp_d     = len_exp_q;
        pay_cnt_d     = pay_cnt_q;
        dout_d        = dout_q;
        dout_valid_d  = 1'b0;
        lpv_d         = lpv_q;
        parity_done_d = parity_done_q;
        hold_ovf_d    = hold_ovf_q;
        err_d         = parity_done_q && (ip_q != pp_q);
        len_err_d     = parity_done_q && (pay_cnt_q != len_exp_q);
        hq_push       = 1'b0;
        hq_pop        = 1'b0;
        hq_wr         = '{tag: TAG_PAYLOAD, data: data_in};

        if (detect_add) begin
            ip_d          = '0;
            pp_d          = '0;
            pay_cnt_d     = '0;
            parity_done_d = 1'b0;
            err_d         = 1'b0;
            len_err_d     = 1'b0;
            hold_ovf_d    = 1'b0;
            if (pkt_valid && addr_valid(int'(data_in[ADDR_W-1:0]), NUM_PORTS)) begin
                hdr_d     = data_in;
                len_exp_d = data_in[DATA_W-1:ADDR_W];
            end
        end else if (lfd_state) begin
            dout_d       = hdr_q;
            dout_valid_d = 1'b1;
            ip_d         = ip_q ^ hdr_q;
        end else if (ld_state) begin
            if (pkt_valid && !full_state) begin
                ip_d = ip_q ^ data_in;
                if (pay_cnt_q != '1) begin
                    pay_cnt_d = pay_cnt_q + LEN_W'(1);
                end
                if (can_emit) begin
                    dout_d       = data_in;
                    dout_valid_d = 1'b1;
                end else begin
                    hq_push = 1'b1;
                    if (hq_full) begin
                        hold_ovf_d = 1'b1;
                    end
                end
            end else if (!pkt_valid) begin
                pp_d  = data_in;
                lpv_d = 1'b1;
                hq_wr = '{tag: TAG_PARITY, data: data_in};
                if (can_emit) begin
                    dout_d        = data_in;
                    dout_valid_d  = 1'b1;
                    parity_done_d = 1'b1;
                end else begin
                    hq_push = 1'b1;
                    if (hq_full) begin
                        hold_ovf_d = 1'b1;
                    end
                end
            end
        end else if (laf_state && !hq_empty && !fifo_full) begin
            hq_pop       = 1'b1;
            dout_d       = hq_rd.data;
            dout_valid_d = 1'b1;
            if (hq_rd.tag == TAG_PARITY) begin
                parity_done_d = 1'b1;
            end
        end

        if (rst_int_reg) begin
            lpv_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hdr_q         <= '0;
            ip_q          <= '0;
            pp_q          <= '0;
            len_exp_q     <= '0;
            pay_cnt_q     <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            lpv_q         <= 1'b0;
            parity_done_q <= 1'b0;
            err_q         <= 1'b0;
            len_err_q     <= 1'b0;
            hold_ovf_q    <= 1'b0;
        end else begin
            hdr_q         <= hdr_d;
            ip_q          <= ip_d;
            pp_q          <= pp_d;
            len_exp_q     <= len_exp_d;
            pay_cnt_q     <= pay_cnt_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            lpv_q         <= lpv_d;
            parity_done_q <= parity_done_d;
            err_q         <= err_d;
            len_err_q     <= len_err_d;
            hold_ovf_q    <= hold_ovf_d;
        end
    end

    assign dout             = dout_q;
    assign dout_valid       = dout_valid_q;
    assign hold_empty       = hq_empty;
    assign low_packet_valid = lpv_q;
    assign parity_done      = parity_done_q;
    assign err              = err_q;
    assign len_err          = len_err_q;
    assign hold_ovf         = hold_ovf_q;

endmodule
